// File: rtl/top_pkg.sv
// Shared defaults and FSM state encoding for the AXI-to-SRAM bridge slice.
package top_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 64;
    localparam int MEM_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRESP = 2'd1,
        RDATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_sram_bridge.sv
// Single-beat AXI slave in front of a synchronous SRAM; one transaction in flight.
module axi_sram_bridge
    import top_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic              rvalid,
    output logic              rlast,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Byte offset within the 8-byte word is dropped, then wrapped into the array.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = a >> 3;
        return IDX_W'(w % ADDR_W'(MEM_WORDS));
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: '0};
    state_t state_r;
    state_t state_next_s;
    logic   wr_en_s;
    logic   rd_en_s;
    logic   unused_wlast;

    assign unused_wlast = wlast;
    assign bvalid = (state_r == WRESP);
    assign rvalid = (state_r == RDATA);
    assign rlast  = (state_r == RDATA);

    // Next-state and handshake decode; a pending write blocks reads until its W arrives.
    always_comb begin
        state_next_s = state_r;
        awready      = 1'b0;
        wready       = 1'b0;
        arready      = 1'b0;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (resetn) begin
                    state_next_s = IDLE;
                end else if (awvalid && wvalid) begin
                    awready      = 1'b1;
                    wready       = 1'b1;
                    wr_en_s      = 1'b1;
                    state_next_s = WRESP;
                end else if (arvalid && !awvalid) begin
                    arready      = 1'b1;
                    rd_en_s      = 1'b1;
                    state_next_s = RDATA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRESP: begin
                if (bready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WRESP;
                end
            end
            RDATA: begin
                if (rready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RDATA;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and read-data capture.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_r <= IDLE;
            rdata   <= '0;
        end else begin
            state_r <= state_next_s;
            if (rd_en_s) begin
                rdata <= mem[word_idx(araddr)];
            end
        end
    end

    // SRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!resetn && wr_en_s) begin
            mem[word_idx(awaddr)] <= wdata;
        end
    end

endmodule

// File: rtl/fake_cpu.sv
// Stub AXI master: drives idle constants, overridden from outside when exercised.
module fake_cpu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata
);

    logic unused_inputs;

    assign awaddr  = '0;
    assign awvalid = 1'b0;
    assign wdata   = '0;
    assign wlast   = 1'b0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b0;
    assign araddr  = '0;
    assign arvalid = 1'b0;
    assign rready  = 1'b0;

    assign unused_inputs = ^{awready, wready, bvalid, arready, rvalid, rdata};

endmodule

// File: rtl/top.sv
// Top: stub AXI master wired to the AXI-to-SRAM bridge.
module top
    import top_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input logic clk,
    input logic resetn
);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              rlast_unused;

    fake_cpu #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) fake_cpu (
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wlast  (wlast),
        .wvalid (wvalid),
        .wready (wready),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata)
    );

    axi_sram_bridge #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS)
    ) bridge (
        .clk    (clk),
        .resetn (resetn),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wlast  (wlast),
        .wvalid (wvalid),
        .wready (wready),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rvalid (rvalid),
        .rlast  (rlast_unused),
        .rready (rready),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_top.sv
// Directed bench for top: stimulus forced onto the fake_cpu nets, responses checked vs constants.
module tb_top;
    import top_pkg::*;

    localparam logic [63:0] D1 = 64'habcdaaaa12345678;
    localparam logic [63:0] D3 = 64'h3333_0000_cafe_f00d;
    localparam logic [63:0] D4 = 64'h4444_1234_5678_9abc;
    localparam logic [63:0] D5 = 64'h5555_dead_beef_0001;

    logic clk;
    logic resetn;
    logic        aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic [31:0] aw_addr, ar_addr;
    logic [63:0] w_data;
    int checks;
    int errors;

    top dut (
        .clk   (clk),
        .resetn(resetn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        force dut.fake_cpu.awvalid = aw_valid;
        force dut.fake_cpu.awaddr  = aw_addr;
        force dut.fake_cpu.wvalid  = w_valid;
        force dut.fake_cpu.wdata   = w_data;
        force dut.fake_cpu.arvalid = ar_valid;
        force dut.fake_cpu.araddr  = ar_addr;
        force dut.fake_cpu.bready  = b_ready;
        force dut.fake_cpu.rready  = r_ready;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        aw_valid = 1'b0; aw_addr = 32'h0; w_valid = 1'b0; w_data = 64'h0;
        ar_valid = 1'b0; ar_addr = 32'h0; b_ready = 1'b0; r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data);
        step();
        idle_all();
        aw_valid = 1'b1; aw_addr = addr; w_valid = 1'b1; w_data = data; b_ready = 1'b1;
        #1;
        check("wr_awready", 64'(dut.fake_cpu.awready), 64'h1);
        check("wr_wready", 64'(dut.fake_cpu.wready), 64'h1);
        step();
        idle_all();
        b_ready = 1'b1;
        #1;
        check("wr_bvalid", 64'(dut.fake_cpu.bvalid), 64'h1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] exp);
        step();
        idle_all();
        ar_valid = 1'b1; ar_addr = addr; r_ready = 1'b1;
        #1;
        check("rd_arready", 64'(dut.fake_cpu.arready), 64'h1);
        step();
        idle_all();
        r_ready = 1'b1;
        #1;
        check("rd_rvalid", 64'(dut.fake_cpu.rvalid), 64'h1);
        check(tag, dut.fake_cpu.rdata, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_all();
        resetn = 1'b1;

        // Reset: readies held low, write attempt must not land.
        step();
        aw_valid = 1'b1; aw_addr = 32'h8; w_valid = 1'b1; w_data = 64'hffff; b_ready = 1'b1;
        #1;
        check("rst_awready", 64'(dut.fake_cpu.awready), 64'h0);
        check("rst_wready", 64'(dut.fake_cpu.wready), 64'h0);
        step();
        idle_all();
        resetn = 1'b0;
        #1;
        check("rst_bvalid", 64'(dut.fake_cpu.bvalid), 64'h0);
        check("rst_rvalid", 64'(dut.fake_cpu.rvalid), 64'h0);
        check("rst_rdata", dut.fake_cpu.rdata, 64'h0);
        check("rst_state", 64'(dut.bridge.state_r), 64'(IDLE));

        // Basic write then read, plus address aliasing.
        do_write(32'h4, D1);
        do_read("rd_0x4", 32'h4, D1);
        do_read("rd_alias_0x0", 32'h0, D1);
        do_read("rd_wrap_0x2004", 32'h2004, D1);
        do_read("rd_unwritten_0x8", 32'h8, 64'h0);

        // Simultaneous AW/W and AR: write first, read sees new data.
        do_write(32'h4, 64'h0123);
        step();
        aw_valid = 1'b1; aw_addr = 32'h4; w_valid = 1'b1; w_data = D1;
        ar_valid = 1'b1; ar_addr = 32'h4; b_ready = 1'b1; r_ready = 1'b1;
        #1;
        check("raw_awready", 64'(dut.fake_cpu.awready), 64'h1);
        check("raw_arready_blocked", 64'(dut.fake_cpu.arready), 64'h0);
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        #1;
        check("raw_bvalid", 64'(dut.fake_cpu.bvalid), 64'h1);
        check("raw_arready_wresp", 64'(dut.fake_cpu.arready), 64'h0);
        step();
        #1;
        check("raw_arready", 64'(dut.fake_cpu.arready), 64'h1);
        step();
        ar_valid = 1'b0;
        #1;
        check("raw_rvalid", 64'(dut.fake_cpu.rvalid), 64'h1);
        check("raw_rdata", dut.fake_cpu.rdata, D1);

        // B backpressure with a read waiting, then R backpressure.
        step();
        idle_all();
        aw_valid = 1'b1; aw_addr = 32'h18; w_valid = 1'b1; w_data = D3;
        ar_valid = 1'b1; ar_addr = 32'h18;
        #1;
        check("bp_awready", 64'(dut.fake_cpu.awready), 64'h1);
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_bvalid_hold", 64'(dut.fake_cpu.bvalid), 64'h1);
            check("bp_arready_hold", 64'(dut.fake_cpu.arready), 64'h0);
            step();
        end
        b_ready = 1'b1;
        #1;
        check("bp_bvalid_last", 64'(dut.fake_cpu.bvalid), 64'h1);
        step();
        b_ready = 1'b0;
        #1;
        check("bp_bvalid_done", 64'(dut.fake_cpu.bvalid), 64'h0);
        check("bp_arready", 64'(dut.fake_cpu.arready), 64'h1);
        step();
        ar_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rbp_rvalid", 64'(dut.fake_cpu.rvalid), 64'h1);
            check("rbp_rdata", dut.fake_cpu.rdata, D3);
            step();
        end
        r_ready = 1'b1;
        #1;
        check("rbp_rvalid_last", 64'(dut.fake_cpu.rvalid), 64'h1);
        step();
        r_ready = 1'b0;
        #1;
        check("rbp_rvalid_done", 64'(dut.fake_cpu.rvalid), 64'h0);

        // AW without W stalls everything until W shows up.
        aw_valid = 1'b1; aw_addr = 32'h20; ar_valid = 1'b1; ar_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("aw_only_awready", 64'(dut.fake_cpu.awready), 64'h0);
            check("aw_only_wready", 64'(dut.fake_cpu.wready), 64'h0);
            check("aw_only_arready", 64'(dut.fake_cpu.arready), 64'h0);
            step();
        end
        ar_valid = 1'b0; w_valid = 1'b1; w_data = D4; b_ready = 1'b1;
        #1;
        check("aw_w_awready", 64'(dut.fake_cpu.awready), 64'h1);
        check("aw_w_wready", 64'(dut.fake_cpu.wready), 64'h1);
        step();
        idle_all();
        b_ready = 1'b1;
        #1;
        check("aw_w_bvalid", 64'(dut.fake_cpu.bvalid), 64'h1);
        do_read("rd_0x20", 32'h20, D4);

        // Reset during WRESP abandons the response but keeps the stored word.
        step();
        idle_all();
        aw_valid = 1'b1; aw_addr = 32'h4; w_valid = 1'b1; w_data = D5;
        #1;
        check("rw_awready", 64'(dut.fake_cpu.awready), 64'h1);
        step();
        idle_all();
        #1;
        check("rw_bvalid", 64'(dut.fake_cpu.bvalid), 64'h1);
        resetn = 1'b1;
        step();
        #1;
        check("rw_bvalid_reset", 64'(dut.fake_cpu.bvalid), 64'h0);
        check("rw_state_reset", 64'(dut.bridge.state_r), 64'(IDLE));
        resetn = 1'b0;
        do_read("rd_after_reset", 32'h4, D5);
        do_read("rd_0x18_kept", 32'h18, D3);

        step();
        idle_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
